// File: rtl/signal_watchdog_mc_pkg.sv
// signal_watchdog_mc_pkg: event cause codes and FSM states shared by the
// multi-antenna signal watchdog.
package signal_watchdog_mc_pkg;
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_LEN  = 2'd1,
        EV_DC   = 2'd2,
        EV_IQEQ = 2'd3
    } ev_code_t;

    typedef enum logic [1:0] {
        S_WD_IDLE = 2'd0,
        S_WD_HOLD = 2'd1,
        S_WD_COOL = 2'd2
    } wd_state_t;
endpackage

// File: rtl/wd_chan_monitor.sv
// wd_chan_monitor: per-channel sign-bias window counter and equal-I/Q run
// counter; window framing comes from the shared sample counter in the top.
module wd_chan_monitor #(
    parameter int IQ_W     = 16,
    parameter int LOG2_WIN = 6,
    parameter int EQ_RUN   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic                iq_valid,
    input  logic                win_last,
    input  logic [IQ_W-1:0]     i_data,
    input  logic [IQ_W-1:0]     q_data,
    input  logic [LOG2_WIN-1:0] dc_th,
    output logic                dc_hit,
    output logic                eq_hit
);
    localparam int RW = $clog2(EQ_RUN + 1);
    localparam logic [LOG2_WIN:0] WIN = {1'b1, {LOG2_WIN{1'b0}}};

    logic [LOG2_WIN:0] pos_cnt;
    logic [LOG2_WIN:0] pos_next;
    logic [RW-1:0]     run_cnt;

    // pos_next already includes the current sample so the last one of a window is judged too
    assign pos_next = pos_cnt + {{LOG2_WIN{1'b0}}, ~i_data[IQ_W-1]};
    assign eq_hit   = run_cnt == RW'(EQ_RUN);

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            pos_cnt <= '0;
            run_cnt <= '0;
            dc_hit  <= 1'b0;
        end else begin
            dc_hit <= iq_valid && win_last &&
                      (pos_next <= {1'b0, dc_th} || pos_next >= WIN - {1'b0, dc_th});
            if (iq_valid) begin
                pos_cnt <= win_last ? '0 : pos_next;
                run_cnt <= (i_data != q_data) ? '0 : (eq_hit ? run_cnt : run_cnt + 1'b1);
            end
        end
    end
endmodule

// File: rtl/signal_watchdog_mc.sv
// signal_watchdog_mc: watches NUM_ANT I/Q channels and the SIG length, and
// pulses receiver_rst on a fault followed by an event-blanking cooldown.
module signal_watchdog_mc
    import signal_watchdog_mc_pkg::*;
#(
    parameter int NUM_ANT  = 2,
    parameter int IQ_W     = 16,
    parameter int LOG2_WIN = 6,
    parameter int EQ_RUN   = 32,
    parameter int COOLDOWN = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic [NUM_ANT*IQ_W-1:0] i_data,
    input  logic [NUM_ANT*IQ_W-1:0] q_data,
    input  logic                    iq_valid,
    input  logic [15:0]             signal_len,
    input  logic                    sig_valid,
    input  logic [15:0]             max_signal_len_th,
    input  logic [15:0]             min_signal_len_th,
    input  logic [LOG2_WIN-1:0]     dc_running_sum_th,
    input  logic [7:0]              rst_hold_cycles,
    output logic                    receiver_rst,
    output logic [1:0]              event_code,
    output logic [15:0]             event_count
);
    localparam int CW = ($clog2(COOLDOWN + 1) > 8) ? $clog2(COOLDOWN + 1) : 8;

    wd_state_t             state;
    logic [CW-1:0]         tmr;
    logic [LOG2_WIN-1:0]   samp_cnt;
    logic [NUM_ANT-1:0]    dc_hit;
    logic [NUM_ANT-1:0]    eq_hit;
    logic                  det_clear;
    logic                  len_hit;
    logic                  dc_any;
    logic                  eq_any;

    // detectors only run while idle and enabled, so every fresh start begins a full window
    assign det_clear = !enable || state != S_WD_IDLE;
    assign len_hit   = enable && sig_valid &&
                       (signal_len > max_signal_len_th || signal_len < min_signal_len_th);
    assign dc_any    = enable && |dc_hit;
    assign eq_any    = enable && |eq_hit;

    always_ff @(posedge clk) begin
        if (!rstn || det_clear)
            samp_cnt <= '0;
        else if (iq_valid)
            samp_cnt <= samp_cnt + 1'b1;
    end

    for (genvar k = 0; k < NUM_ANT; k++) begin : g_chan
        wd_chan_monitor #(
            .IQ_W(IQ_W),
            .LOG2_WIN(LOG2_WIN),
            .EQ_RUN(EQ_RUN)
        ) u_mon (
            .clk(clk),
            .rstn(rstn),
            .clear(det_clear),
            .iq_valid(iq_valid),
            .win_last(&samp_cnt),
            .i_data(i_data[k*IQ_W +: IQ_W]),
            .q_data(q_data[k*IQ_W +: IQ_W]),
            .dc_th(dc_running_sum_th),
            .dc_hit(dc_hit[k]),
            .eq_hit(eq_hit[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_WD_IDLE;
            tmr          <= '0;
            receiver_rst <= 1'b0;
            event_code   <= EV_NONE;
            event_count  <= '0;
        end else begin
            case (state)
                S_WD_IDLE: begin
                    if (len_hit || dc_any || eq_any) begin
                        state        <= S_WD_HOLD;
                        receiver_rst <= 1'b1;
                        event_code   <= len_hit ? EV_LEN : (dc_any ? EV_DC : EV_IQEQ);
                        event_count  <= event_count + {15'd0, event_count != 16'hFFFF};
                        tmr          <= (rst_hold_cycles == 8'd0) ? CW'(1) : CW'(rst_hold_cycles);
                    end
                end
                S_WD_HOLD: begin
                    if (tmr == CW'(1)) begin
                        state        <= S_WD_COOL;
                        receiver_rst <= 1'b0;
                        tmr          <= CW'(COOLDOWN);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    if (tmr == CW'(1))
                        state <= S_WD_IDLE;
                    else
                        tmr <= tmr - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_signal_watchdog_mc.sv
// tb_signal_watchdog_mc: directed and randomized stimulus checked every cycle
// against a timeline model of events, hold pulses and cooldown windows.
module tb_signal_watchdog_mc;
    localparam int NA  = 2;
    localparam int W   = 16;
    localparam int LW  = 6;
    localparam int EQR = 32;
    localparam int CD  = 64;
    localparam int WIN = 64;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            enable = 1'b0;
    logic [NA*W-1:0] i_data = '0;
    logic [NA*W-1:0] q_data = '0;
    logic            iq_valid = 1'b0;
    logic [15:0]     signal_len = 16'd100;
    logic            sig_valid = 1'b0;
    logic [15:0]     max_th = 16'd4095;
    logic [15:0]     min_th = 16'd14;
    logic [LW-1:0]   dc_th = 6'd4;
    logic [7:0]      hold = 8'd10;
    logic            receiver_rst;
    logic [1:0]      event_code;
    logic [15:0]     event_count;

    always #5 clk = ~clk;

    signal_watchdog_mc #(
        .NUM_ANT(NA), .IQ_W(W), .LOG2_WIN(LW), .EQ_RUN(EQR), .COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .i_data(i_data),
        .q_data(q_data),
        .iq_valid(iq_valid),
        .signal_len(signal_len),
        .sig_valid(sig_valid),
        .max_signal_len_th(max_th),
        .min_signal_len_th(min_th),
        .dc_running_sum_th(dc_th),
        .rst_hold_cycles(hold),
        .receiver_rst(receiver_rst),
        .event_code(event_code),
        .event_count(event_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: t is the current cycle; an event accepted at the end of cycle t0
    // drives receiver_rst over t0+1..t0+hl and blanks through t0+hl+CD
    int          t = 0;
    int          t0 = 0;
    int          hl = 1;
    bit          ev = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [15:0] m_cnt = 16'd0;
    int          nsamp = 0;
    int          pos[NA];
    int          run[NA];
    bit          dcf[NA];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    function automatic bit idle_now();
        return !ev || t > t0 + hl + CD;
    endfunction

    task automatic clr();
        nsamp = 0;
        for (int k = 0; k < NA; k++) begin
            pos[k] = 0;
            run[k] = 0;
            dcf[k] = 1'b0;
        end
    endtask

    task automatic step();
        bit act, lh, dh, eh, e_rst;
        logic [W-1:0] iv, qv;
        if (!rstn) begin
            ev = 1'b0;
            m_code = 2'd0;
            m_cnt = 16'd0;
            clr();
        end else begin
            act = enable && idle_now();
            lh = sig_valid && (signal_len > max_th || signal_len < min_th);
            dh = 1'b0;
            eh = 1'b0;
            for (int k = 0; k < NA; k++) begin
                dh |= dcf[k];
                eh |= (run[k] >= EQR);
            end
            if (act && (lh || dh || eh)) begin
                ev = 1'b1;
                t0 = t;
                hl = (hold == 8'd0) ? 1 : int'(hold);
                m_code = lh ? 2'd1 : (dh ? 2'd2 : 2'd3);
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            if (!act) clr();
            else begin
                for (int k = 0; k < NA; k++) begin
                    dcf[k] = 1'b0;
                    if (iq_valid) begin
                        iv = i_data[k*W +: W];
                        qv = q_data[k*W +: W];
                        if (!iv[W-1]) pos[k]++;
                        run[k] = (iv == qv) ? ((run[k] < EQR) ? run[k] + 1 : EQR) : 0;
                    end
                end
                if (iq_valid) begin
                    nsamp++;
                    if (nsamp == WIN) begin
                        for (int k = 0; k < NA; k++) begin
                            dcf[k] = (pos[k] <= int'(dc_th)) || (pos[k] >= WIN - int'(dc_th));
                            pos[k] = 0;
                        end
                        nsamp = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        t++;
        e_rst = ev && t >= t0 + 1 && t <= t0 + hl;
        chk("receiver_rst", {15'd0, receiver_rst}, {15'd0, e_rst});
        chk("event_code", {14'd0, event_code}, {14'd0, m_code});
        chk("event_count", event_count, m_cnt);
    endtask

    function automatic logic [15:0] rnd();
        return 16'($urandom);
    endfunction

    task automatic feed(input logic [W-1:0] i0, q0, i1, q1, input bit v);
        i_data = {i1, i0};
        q_data = {q1, q0};
        iq_valid = v;
    endtask

    task automatic rnd_samples();
        feed(rnd(), rnd(), rnd(), rnd(), 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        sig_valid = 1'b0;
        while (!idle_now() && n < 300) begin
            rnd_samples();
            step();
            n++;
        end
        chk("wait_idle_bound", {15'd0, n >= 300}, 16'd0);
    endtask

    task automatic len_fault(input logic [15:0] len);
        signal_len = len;
        sig_valid = 1'b1;
        rnd_samples();
        step();
        sig_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [W-1:0] a[NA];
        logic [W-1:0] b[NA];
        clr();
        repeat (3) step();
        chk("reset_rst", {15'd0, receiver_rst}, 16'd0);
        chk("reset_code", {14'd0, event_code}, 16'd0);
        chk("reset_count", event_count, 16'd0);
        rstn = 1'b1;
        enable = 1'b1;

        // DC bias on channel 1 across a full window
        for (int i = 0; i < WIN; i++) begin
            feed(rnd(), rnd(), 16'd100, rnd(), 1'b1);
            step();
        end
        chk("dc_no_rst_at_hit_cycle", {15'd0, receiver_rst}, 16'd0);
        rnd_samples();
        step();
        chk("dc_rst_rise", {15'd0, receiver_rst}, 16'd1);
        n = 0;
        while (receiver_rst === 1'b1 && n < 40) begin
            n++;
            rnd_samples();
            step();
        end
        chk("dc_hold_cycles", 16'(n), 16'd10);
        chk("dc_code", {14'd0, event_code}, 16'd2);
        chk("dc_count", event_count, 16'd1);
        wait_idle();

        // length faults and inclusive bounds
        len_fault(16'd5000);
        chk("len_rst_next", {15'd0, receiver_rst}, 16'd1);
        chk("len_code", {14'd0, event_code}, 16'd1);
        chk("len_count", event_count, 16'd2);
        wait_idle();
        len_fault(16'd1537);
        len_fault(16'd4095);
        len_fault(16'd14);
        chk("len_inrange_rst", {15'd0, receiver_rst}, 16'd0);
        chk("len_inrange_count", event_count, 16'd2);
        len_fault(16'd13);
        chk("len_below_min_rst", {15'd0, receiver_rst}, 16'd1);
        chk("len_below_min_count", event_count, 16'd3);
        wait_idle();

        // equal I/Q run on channel 0
        for (int i = 0; i < EQR; i++) begin
            feed(16'd37, 16'd37, rnd(), rnd(), 1'b1);
            step();
        end
        rnd_samples();
        step();
        chk("eq_rst", {15'd0, receiver_rst}, 16'd1);
        chk("eq_code", {14'd0, event_code}, 16'd3);
        chk("eq_count", event_count, 16'd4);
        wait_idle();
        for (int i = 0; i < EQR - 1; i++) begin
            feed(16'd37, 16'd37, rnd(), rnd(), 1'b1);
            step();
        end
        feed(16'd37, 16'd38, rnd(), rnd(), 1'b1);
        step();
        repeat (40) begin
            rnd_samples();
            step();
        end
        chk("eq31_no_event", event_count, 16'd4);

        // length and DC in the same cycle, then a fault during cooldown
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            feed(rnd(), rnd(), 16'd100, rnd(), 1'b1);
            step();
        end
        len_fault(16'd5000);
        chk("both_rst", {15'd0, receiver_rst}, 16'd1);
        chk("both_code", {14'd0, event_code}, 16'd1);
        chk("both_count", event_count, 16'd5);
        repeat (20) begin
            rnd_samples();
            step();
        end
        len_fault(16'd5000);
        repeat (5) step();
        chk("cooldown_ignored_count", event_count, 16'd5);
        wait_idle();

        // disabled detection, then a fresh full window after enable rises
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            feed(rnd(), rnd(), 16'd100, rnd(), 1'b1);
            step();
        end
        chk("disabled_rst", {15'd0, receiver_rst}, 16'd0);
        chk("disabled_count", event_count, 16'd5);
        enable = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            feed(rnd(), rnd(), 16'd100, rnd(), 1'b1);
            step();
        end
        chk("enable_window_rst_low", {15'd0, receiver_rst}, 16'd0);
        feed(rnd(), rnd(), 16'd100, rnd(), 1'b1);
        step();
        chk("enable_window_rst_high", {15'd0, receiver_rst}, 16'd1);
        chk("enable_window_count", event_count, 16'd6);
        wait_idle();

        // zero hold gives a single-cycle pulse
        hold = 8'd0;
        len_fault(16'd5000);
        chk("hold0_high", {15'd0, receiver_rst}, 16'd1);
        rnd_samples();
        step();
        chk("hold0_low", {15'd0, receiver_rst}, 16'd0);
        wait_idle();
        hold = 8'd10;

        // reset in the middle of a hold
        len_fault(16'd5000);
        step();
        step();
        chk("midhold_rst_high", {15'd0, receiver_rst}, 16'd1);
        rstn = 1'b0;
        step();
        chk("midhold_reset_rst", {15'd0, receiver_rst}, 16'd0);
        chk("midhold_reset_count", event_count, 16'd0);
        rstn = 1'b1;

        // saturating event counter
        force dut.event_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.event_count;
        len_fault(16'd5000);
        chk("sat_count", event_count, 16'hFFFF);
        chk("sat_rst", {15'd0, receiver_rst}, 16'd1);
        wait_idle();

        // randomized segments
        for (int s = 0; s < 60; s++) begin
            int mode, c, len;
            bit neg;
            mode = $urandom_range(0, 2);
            c = $urandom_range(0, NA - 1);
            neg = 1'($urandom % 2);
            len = $urandom_range(1, 120);
            enable = ($urandom % 8) != 0;
            hold = 8'($urandom_range(0, 15));
            dc_th = 6'($urandom_range(0, 10));
            for (int j = 0; j < len; j++) begin
                for (int k = 0; k < NA; k++) begin
                    a[k] = rnd();
                    b[k] = rnd();
                end
                if (mode == 1 && ($urandom % 20) != 0)
                    a[c] = neg ? (a[c] | 16'h8000) : (a[c] & 16'h7FFF);
                if (mode == 2 && ($urandom % 60) != 0)
                    b[c] = a[c];
                i_data = {a[1], a[0]};
                q_data = {b[1], b[0]};
                iq_valid = ($urandom % 4) != 0;
                sig_valid = ($urandom % 50) == 0;
                signal_len = 16'($urandom_range(0, 6000));
                rstn = ($urandom % 500) != 0;
                step();
            end
        end
        rstn = 1'b1;
        sig_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/signal_watchdog_mc.md
Name: signal_watchdog_mc

Overview:
- Multi-antenna, parametrised successor to the single-channel signal watchdog.
- Sits between the ADC sample stream and the dot11 receiver reset input.
- Monitors NUM_ANT I/Q channels for three fault classes: DC/stuck sign bias, frozen I==Q samples, and out-of-range SIG length.
- On a fault, asserts receiver_rst for a programmable hold time, then blanks further events for a cooldown period. Reports the cause and a saturating event counter.

Parameters:
NUM_ANT, 2, number of antenna channels (1..4)
IQ_W, 16, width of each I or Q sample
LOG2_WIN, 6, DC window length = 2^LOG2_WIN valid samples
EQ_RUN, 32, consecutive I==Q samples on one channel that count as a fault
COOLDOWN, 64, clk cycles of event blanking after the hold ends

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
enable  in  1  detection enable; low while demod ongoing
i_data  in  NUM_ANT*IQ_W  I samples, channel k at [k*IQ_W +: IQ_W]
q_data  in  NUM_ANT*IQ_W  Q samples, same packing
iq_valid  in  1  sample strobe, common to all channels
signal_len  in  16  decoded packet length (bytes)
sig_valid  in  1  one-cycle strobe: signal_len is valid
max_signal_len_th  in  16  length upper bound (inclusive ok)
min_signal_len_th  in  16  length lower bound (inclusive ok)
dc_running_sum_th  in  LOG2_WIN  sign-bias tolerance
rst_hold_cycles  in  8  receiver_rst pulse length; 0 treated as 1
receiver_rst  out  1  reset request to receiver
event_code  out  2  last cause: 0 none, 1 length, 2 DC, 3 equal-IQ
event_count  out  16  saturating count of accepted events

Behaviour:
- Reset (rstn=0 at a clk edge): receiver_rst=0, event_code=0, event_count=0. All window counters, run counters and FSM state are cleared; FSM goes to IDLE.
- Sign convention: a sample is non-negative when its MSB is 0.
- DC detector, per channel:
  - Count the non-negative I samples over each window of 2^LOG2_WIN iq_valid strobes. Windows are non-overlapping, and one shared sample counter wraps to 0.
  - At window end: dc_hit[k]=1 if pos_cnt <= th or pos_cnt >= 2^LOG2_WIN - th. The pos_cnt counter is LOG2_WIN+1 bits.
  - The window-end comparison is registered; it is valid the cycle after the last iq_valid.
- Equal-IQ detector, per channel:
  - Run counter increments on iq_valid when I==Q and clears when I!=Q.
  - eq_hit[k]=1 when the counter reaches EQ_RUN. The counter saturates at EQ_RUN.
- Length detector: len_hit=1 in the cycle sig_valid=1 and (signal_len > max_signal_len_th or signal_len < min_signal_len_th). The comparison is combinational on the strobe.
- enable=0: all detector counters are held at 0 and no hits are generated. An in-progress RST_HOLD/COOLDOWN still completes.
- FSM:
  - IDLE: any hit → RST_HOLD. Latch event_code with priority length > DC > equal-IQ. Increment event_count, saturating at 16'hFFFF. Load hold counter with max(rst_hold_cycles,1).
  - RST_HOLD: receiver_rst=1. Hold counter decrements each cycle; at 1 → COOLDOWN, load COOLDOWN.
  - COOLDOWN: receiver_rst=0. Hits are ignored and not counted. Detector counters are held cleared. At counter 1 → IDLE.
- Latency:
  - Hit registered at cycle N → receiver_rst=1 from N+1 for exactly hold cycles.
  - Length fault: sig_valid at cycle N → receiver_rst high at N+1.
- Simultaneous hits: one event only; event_code follows the priority order; event_count +1.
- event_code holds its value until the next accepted event or reset.
- Reset mid-hold: receiver_rst drops at the reset edge. The next cycle is IDLE with cleared counters.

Decomposition:
- Shared package holds:
  - event_code constants EV_NONE, EV_LEN, EV_DC, EV_IQEQ.
  - FSM state encodings S_WD_IDLE, S_WD_HOLD, S_WD_COOL.
- One sub-module, wd_chan_monitor: per-channel DC window counter plus equal-IQ run counter. It outputs dc_hit and eq_hit and is instantiated NUM_ANT times by generate.
- The shared window sample counter lives in the top module.

Test Plan:
- NUM_ANT=2, th=4. Ch1 fed 64 samples all I=+100, ch0 random → dc_hit at window end; receiver_rst high 1 cycle later for rst_hold_cycles=10 cycles; event_code=2, event_count=1.
- sig_valid with signal_len=5000, max=4095, min=14 → receiver_rst high the next cycle; event_code=1. Then signal_len=1537 → no reset.
- Ch0 fed 32 consecutive samples with I=Q=37 → event_code=3. A run of 31 followed by one mismatch → no event.
- Length and DC faults in the same cycle → single event, event_code=1, event_count increments by 1. A second fault during the 64-cycle cooldown → ignored, count unchanged.
- enable=0 with constant-DC input for 200 samples → receiver_rst stays 0. After enable rises, a fault is flagged only after one full fresh window.
- rst_hold_cycles=0 → one-cycle pulse. rstn low during the hold → receiver_rst=0, event_count=0 the next cycle. Force event_count to 16'hFFFF, inject a fault → count stays 16'hFFFF.
